// File: rtl/flag_branch_controller.sv
// flag_branch_controller
//
// Resolves conditional jumps against the flag register of the pipelined core.
// The block counts in-flight flag writers (S_AL instructions). It holds
// fetch/decode while a conditional jump waits for the flags to settle. It then
// presents the jump condition on oc_fl and samples the selected flag on fl. A
// taken jump redirects the PC and squashes the wrong-path slots for a fixed
// number of cycles.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous, active-high reset
//   issue_valid  in   decode presents an instruction this cycle
//   issue_sal    in   instruction updates flags (S_AL)
//   issue_jcc    in   instruction is a conditional jump
//   issue_cond   in   jump condition (0 Z, 1 NZ, 2 C, 3 NC, 4 P, 5 N, 6 PO, 7 PE)
//   issue_target in   jump target
//   fl           in   selected flag from the flag register
//   oc_fl        out  condition select to the flag register (registered)
//   stall        out  hold fetch/decode; the instruction is not accepted
//   redirect     out  one-cycle pulse: load PC with redirect_pc
//   redirect_pc  out  latched jump target
//   flush        out  squash wrong-path fetch/decode slots
//   jcc_done     out  one-cycle pulse when a jump resolves

module flag_branch_controller #(
    parameter int FLAG_LAT  = 3,
    parameter int FLUSH_CYC = 2,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              issue_sal,
    input  logic              issue_jcc,
    input  logic [2:0]        issue_cond,
    input  logic [ADDR_W-1:0] issue_target,
    input  logic              fl,
    output logic [2:0]        oc_fl,
    output logic              stall,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic              jcc_done
);

    localparam int CNT_W = $clog2(FLUSH_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_EVAL  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [FLAG_LAT-1:0] pend_q, pend_d;
    logic [2:0]          cond_q, cond_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sal_ins_s;
    logic                pend_zero_s;

    // A jump may only be evaluated once no flag writer is still in flight.
    assign pend_zero_s = (pend_q == {FLAG_LAT{1'b0}});
    assign oc_fl       = cond_q;
    assign redirect_pc = pc_q;

    // Next-state, datapath and output decode for the jump sequencer.
    always_comb begin
        state_d   = state_q;
        cond_d    = cond_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        sal_ins_s = 1'b0;
        stall     = 1'b0;
        redirect  = 1'b0;
        flush     = 1'b0;
        jcc_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = 1'b0;
                if (issue_valid) begin
                    // A jump takes priority over its own S_AL bit.
                    if (issue_jcc) begin
                        cond_d = issue_cond;
                        pc_d   = issue_target;
                        if (pend_zero_s) begin
                            state_d = S_EVAL;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else if (issue_sal) begin
                        sal_ins_s = 1'b1;
                    end else begin
                        sal_ins_s = 1'b0;
                    end
                end else begin
                    sal_ins_s = 1'b0;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (pend_zero_s) begin
                    state_d = S_EVAL;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_EVAL: begin
                stall    = 1'b1;
                jcc_done = 1'b1;
                if (fl) begin
                    redirect = 1'b1;
                    flush    = 1'b1;
                    cnt_d    = CNT_W'(FLUSH_CYC);
                    state_d  = S_FLUSH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                stall = 1'b1;
                flush = 1'b1;
                // The counter was loaded with FLUSH_CYC, so leaving on 1 gives exactly FLUSH_CYC cycles.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = S_FLUSH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pending-writer pipe: a marker enters at bit 0 and ages one slot per cycle.
    always_comb begin
        pend_d    = {FLAG_LAT{1'b0}};
        pend_d[0] = sal_ins_s;
        for (int i = 1; i < FLAG_LAT; i++) begin
            pend_d[i] = pend_q[i-1];
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= {FLAG_LAT{1'b0}};
            cond_q  <= 3'd0;
            pc_q    <= {ADDR_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cond_q  <= cond_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_flag_branch_controller.sv
// Directed bench for flag_branch_controller (FLAG_LAT=3, FLUSH_CYC=2, ADDR_W=8).
// Inputs change 1 time unit after a rising edge. Outputs are sampled on the
// falling edge of the same cycle.

module tb_flag_branch_controller;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic              issue_sal;
    logic              issue_jcc;
    logic [2:0]        issue_cond;
    logic [ADDR_W-1:0] issue_target;
    logic              fl;
    logic [2:0]        oc_fl;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush;
    logic              jcc_done;

    int tests_run    = 0;
    int tests_failed = 0;

    flag_branch_controller #(
        .FLAG_LAT  (3),
        .FLUSH_CYC (2),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_sal    (issue_sal),
        .issue_jcc    (issue_jcc),
        .issue_cond   (issue_cond),
        .issue_target (issue_target),
        .fl           (fl),
        .oc_fl        (oc_fl),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .flush        (flush),
        .jcc_done     (jcc_done)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_issue();
        issue_valid  = 1'b0;
        issue_sal    = 1'b0;
        issue_jcc    = 1'b0;
        issue_cond   = 3'd0;
        issue_target = 8'h00;
    endtask

    task automatic drive_jcc(input logic [2:0] cond, input logic [7:0] tgt);
        issue_valid  = 1'b1;
        issue_sal    = 1'b0;
        issue_jcc    = 1'b1;
        issue_cond   = cond;
        issue_target = tgt;
    endtask

    task automatic drive_sal();
        issue_valid  = 1'b1;
        issue_sal    = 1'b1;
        issue_jcc    = 1'b0;
        issue_cond   = 3'd0;
        issue_target = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fl  = 1'b0;
        clear_issue();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        repeat (5) next_cycle();
        #4;
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %0b want 0", stall); end
        tests_run++; if (redirect !== 1'b0) begin tests_failed++; $display("FAIL reset_redirect: got %0b want 0", redirect); end
        tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL reset_flush: got %0b want 0", flush); end
        tests_run++; if (jcc_done !== 1'b0) begin tests_failed++; $display("FAIL reset_jcc_done: got %0b want 0", jcc_done); end
        tests_run++; if (oc_fl !== 3'd0) begin tests_failed++; $display("FAIL reset_oc_fl: got %0d want 0", oc_fl); end
        tests_run++; if (redirect_pc !== 8'h00) begin tests_failed++; $display("FAIL reset_redirect_pc: got %0h want 0", redirect_pc); end
    endtask

    // Jump taken with no pending writers: EVAL at T+1, flush T+1..T+3, idle at T+4.
    task automatic test_taken();
        next_cycle();
        drive_jcc(3'd0, 8'h40);
        fl = 1'b1;
        #4;
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL taken_accept_stall: got %0b want 0", stall); end
        next_cycle();
        clear_issue();
        #4;
        tests_run++; if (redirect !== 1'b1) begin tests_failed++; $display("FAIL taken_redirect: got %0b want 1", redirect); end
        tests_run++; if (jcc_done !== 1'b1) begin tests_failed++; $display("FAIL taken_jcc_done: got %0b want 1", jcc_done); end
        tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("FAIL taken_flush_t1: got %0b want 1", flush); end
        tests_run++; if (redirect_pc !== 8'h40) begin tests_failed++; $display("FAIL taken_redirect_pc: got %0h want 40", redirect_pc); end
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL taken_eval_stall: got %0b want 1", stall); end
        next_cycle();
        drive_jcc(3'd7, 8'h99);
        #4;
        tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("FAIL taken_flush_t2: got %0b want 1", flush); end
        tests_run++; if (redirect !== 1'b0) begin tests_failed++; $display("FAIL taken_redirect_pulse: got %0b want 0", redirect); end
        tests_run++; if (jcc_done !== 1'b0) begin tests_failed++; $display("FAIL taken_done_pulse: got %0b want 0", jcc_done); end
        tests_run++; if (oc_fl !== 3'd0) begin tests_failed++; $display("FAIL taken_oc_fl_hold: got %0d want 0", oc_fl); end
        next_cycle();
        #4;
        tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("FAIL taken_flush_t3: got %0b want 1", flush); end
        next_cycle();
        clear_issue();
        fl = 1'b0;
        #4;
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL taken_t4_stall: got %0b want 0", stall); end
        tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL taken_t4_flush: got %0b want 0", flush); end
        tests_run++; if (redirect_pc !== 8'h40) begin tests_failed++; $display("FAIL taken_pc_kept: got %0h want 40", redirect_pc); end
    endtask

    // ALU at cycle 0, jcc NC at cycle 1, fl=0: stall 2..5, done at 5, free at 6.
    task automatic test_alu_then_jcc();
        logic exp_stall;
        logic exp_done;
        next_cycle();
        fl = 1'b0;
        drive_sal();
        #4;
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL alu_accept_stall: got %0b want 0", stall); end
        next_cycle();
        drive_jcc(3'd3, 8'h22);
        for (int c = 2; c <= 6; c++) begin
            next_cycle();
            clear_issue();
            #4;
            exp_stall = (c <= 5);
            exp_done  = (c == 5);
            tests_run++; if (stall !== exp_stall) begin tests_failed++; $display("FAIL alu_jcc_stall c%0d: got %0b want %0b", c, stall, exp_stall); end
            tests_run++; if (jcc_done !== exp_done) begin tests_failed++; $display("FAIL alu_jcc_done c%0d: got %0b want %0b", c, jcc_done, exp_done); end
            tests_run++; if (redirect !== 1'b0) begin tests_failed++; $display("FAIL alu_jcc_redirect c%0d: got %0b want 0", c, redirect); end
            if (c == 2) begin
                tests_run++; if (oc_fl !== 3'd3) begin tests_failed++; $display("FAIL alu_jcc_oc_fl: got %0d want 3", oc_fl); end
            end
        end
    endtask

    // Two ALU ops then jcc at cycle 2: EVAL at 6; jcc re-issued during stall is ignored.
    task automatic test_back_to_back();
        logic exp_stall;
        logic exp_done;
        int   done_count;
        done_count = 0;
        next_cycle();
        fl = 1'b0;
        drive_sal();
        next_cycle();
        drive_sal();
        next_cycle();
        drive_jcc(3'd5, 8'h33);
        for (int c = 3; c <= 9; c++) begin
            next_cycle();
            if (c <= 6) begin
                drive_jcc(3'd2, 8'h77);
            end else begin
                clear_issue();
            end
            #4;
            exp_stall = (c <= 6);
            exp_done  = (c == 6);
            if (jcc_done === 1'b1) begin
                done_count++;
            end
            tests_run++; if (stall !== exp_stall) begin tests_failed++; $display("FAIL b2b_stall c%0d: got %0b want %0b", c, stall, exp_stall); end
            tests_run++; if (jcc_done !== exp_done) begin tests_failed++; $display("FAIL b2b_done c%0d: got %0b want %0b", c, jcc_done, exp_done); end
        end
        tests_run++; if (done_count != 1) begin tests_failed++; $display("FAIL b2b_done_count: got %0d want 1", done_count); end
        tests_run++; if (redirect_pc !== 8'h33) begin tests_failed++; $display("FAIL b2b_redirect_pc: got %0h want 33", redirect_pc); end
        tests_run++; if (oc_fl !== 3'd5) begin tests_failed++; $display("FAIL b2b_oc_fl: got %0d want 5", oc_fl); end
    endtask

    // sal+jcc together: jcc wins, no writer enters the pipe, so a following jcc evaluates at once.
    task automatic test_sal_jcc_both();
        next_cycle();
        fl = 1'b0;
        issue_valid  = 1'b1;
        issue_sal    = 1'b1;
        issue_jcc    = 1'b1;
        issue_cond   = 3'd1;
        issue_target = 8'h55;
        #4;
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL both_accept_stall: got %0b want 0", stall); end
        next_cycle();
        clear_issue();
        #4;
        tests_run++; if (jcc_done !== 1'b1) begin tests_failed++; $display("FAIL both_eval_done: got %0b want 1", jcc_done); end
        tests_run++; if (oc_fl !== 3'd1) begin tests_failed++; $display("FAIL both_oc_fl: got %0d want 1", oc_fl); end
        next_cycle();
        drive_jcc(3'd2, 8'h66);
        #4;
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL both_second_stall: got %0b want 0", stall); end
        next_cycle();
        clear_issue();
        fl = 1'b1;
        #4;
        tests_run++; if (jcc_done !== 1'b1) begin tests_failed++; $display("FAIL both_pend_empty_done: got %0b want 1", jcc_done); end
        tests_run++; if (redirect !== 1'b1) begin tests_failed++; $display("FAIL both_redirect: got %0b want 1", redirect); end
        tests_run++; if (redirect_pc !== 8'h66) begin tests_failed++; $display("FAIL both_redirect_pc: got %0h want 66", redirect_pc); end
        next_cycle();
        fl = 1'b0;
        next_cycle();
        next_cycle();
        #4;
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL both_back_idle: got %0b want 0", stall); end
    endtask

    // Reset in the first FLUSH cycle clears everything; a jump is accepted right after.
    task automatic test_reset_in_flush();
        next_cycle();
        drive_jcc(3'd6, 8'hA5);
        fl = 1'b1;
        #4;
        next_cycle();
        clear_issue();
        #4;
        tests_run++; if (redirect !== 1'b1) begin tests_failed++; $display("FAIL rstf_redirect: got %0b want 1", redirect); end
        next_cycle();
        rst = 1'b1;
        #4;
        tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("FAIL rstf_flush_before: got %0b want 1", flush); end
        next_cycle();
        rst = 1'b0;
        #4;
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL rstf_stall: got %0b want 0", stall); end
        tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL rstf_flush: got %0b want 0", flush); end
        tests_run++; if (redirect !== 1'b0) begin tests_failed++; $display("FAIL rstf_redirect_after: got %0b want 0", redirect); end
        tests_run++; if (jcc_done !== 1'b0) begin tests_failed++; $display("FAIL rstf_jcc_done: got %0b want 0", jcc_done); end
        tests_run++; if (oc_fl !== 3'd0) begin tests_failed++; $display("FAIL rstf_oc_fl: got %0d want 0", oc_fl); end
        tests_run++; if (redirect_pc !== 8'h00) begin tests_failed++; $display("FAIL rstf_redirect_pc: got %0h want 0", redirect_pc); end
        drive_jcc(3'd7, 8'h12);
        fl = 1'b0;
        next_cycle();
        clear_issue();
        #4;
        tests_run++; if (jcc_done !== 1'b1) begin tests_failed++; $display("FAIL rstf_accept_done: got %0b want 1", jcc_done); end
        tests_run++; if (oc_fl !== 3'd7) begin tests_failed++; $display("FAIL rstf_accept_oc_fl: got %0d want 7", oc_fl); end
        tests_run++; if (redirect_pc !== 8'h12) begin tests_failed++; $display("FAIL rstf_accept_pc: got %0h want 12", redirect_pc); end
    endtask

    initial begin
        test_reset();
        test_taken();
        test_alu_then_jcc();
        test_back_to_back();
        test_sal_jcc_both();
        test_reset_in_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
